// File: rtl/rc_vc_route_stage.sv
// rc_vc_route_stage: west-first adaptive route computation, route locked per (input port, input VC) from head to tail.
// Latency: 1 cycle through one registered valid/ready slot per input port; 1 flit/cycle/port throughput.
// Backpressure: in_ready[p] = !out_valid[p] || out_ready[p]; out_* hold while out_valid & !out_ready.
// Optional feature macro: RC_ERR_EN (sticky err, orphan body/tail drop, out-of-range dest to L/VC0).
module rc_vc_route_stage #(
  parameter int FLIT_W  = 64,
  parameter int COORD_W = 3,
  parameter int NUM_VC  = 2,
  parameter int MESH_X  = 4,
  parameter int MESH_Y  = 4,
  localparam int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [COORD_W-1:0]    curr_x,
  input  logic [COORD_W-1:0]    curr_y,
  input  logic [5*FLIT_W-1:0]   in_flit,
  input  logic [5*VC_W-1:0]     in_vc,
  input  logic [4:0]            in_valid,
  output logic [4:0]            in_ready,
  input  logic [5*NUM_VC-1:0]   vc_avail,
  output logic [5*FLIT_W-1:0]   out_flit,
  output logic [5*VC_W-1:0]     out_ivc,
  output logic [14:0]           out_port,
  output logic [5*VC_W-1:0]     out_ovc,
  output logic [4:0]            out_valid,
  input  logic [4:0]            out_ready,
  output logic [4:0]            err
);

  localparam logic [2:0] FT_HEAD   = 3'b000;
  localparam logic [2:0] FT_TAIL   = 3'b010;
  localparam logic [2:0] FT_SINGLE = 3'b011;

  localparam logic [2:0] P_N = 3'd0;
  localparam logic [2:0] P_E = 3'd1;
  localparam logic [2:0] P_S = 3'd2;
  localparam logic [2:0] P_W = 3'd3;
  localparam logic [2:0] P_L = 3'd4;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} rt_state_e;

  // The mesh must be addressable by the coordinate fields.
  if (MESH_X > (1 << COORD_W) || MESH_Y > (1 << COORD_W)) begin : g_bad_cfg
    $error("rc_vc_route_stage: mesh does not fit in COORD_W bits");
  end

  // Index of the lowest free VC in a mask, 0 when the mask is empty.
  function automatic logic [VC_W-1:0] low_vc(input logic [NUM_VC-1:0] mask);
    logic [VC_W-1:0] r;
    r = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (mask[i]) r = VC_W'(i);
    end
    return r;
  endfunction

  for (genvar p = 0; p < 5; p++) begin : g_port
    logic [FLIT_W-1:0]  flit;
    logic [COORD_W-1:0] dst_x, dst_y;
    logic [2:0]         ftype;
    logic [VC_W-1:0]    ivc;
    logic               is_head, is_single, is_tail, is_start, xfer, fwd_d;
    logic               prod_n, prod_s, prod_e, avail_n, avail_s, avail_e;
    logic [2:0]         route_port, port_d;
    logic [VC_W-1:0]    route_ovc, ovc_d;

    rt_state_e          state_q    [NUM_VC];
    logic [2:0]         tbl_port_q [NUM_VC];
    logic [VC_W-1:0]    tbl_ovc_q  [NUM_VC];

    logic               valid_q;
    logic [FLIT_W-1:0]  flit_q;
    logic [VC_W-1:0]    ivc_q, ovc_q;
    logic [2:0]         port_q;

    assign flit      = in_flit[p*FLIT_W +: FLIT_W];
    assign dst_y     = flit[FLIT_W-1 -: COORD_W];
    assign dst_x     = flit[FLIT_W-1-COORD_W -: COORD_W];
    assign ftype     = flit[FLIT_W-1-2*COORD_W -: 3];
    assign ivc       = in_vc[p*VC_W +: VC_W];
    assign is_head   = (ftype == FT_HEAD);
    assign is_single = (ftype == FT_SINGLE);
    assign is_tail   = (ftype == FT_TAIL);
    assign is_start  = is_head || is_single;

    assign in_ready[p] = !valid_q || out_ready[p];
    assign xfer        = in_valid[p] && in_ready[p];

    assign prod_n  = (dst_y > curr_y);
    assign prod_s  = (dst_y < curr_y);
    assign prod_e  = (dst_x > curr_x);
    assign avail_n = |vc_avail[0*NUM_VC +: NUM_VC];
    assign avail_e = |vc_avail[1*NUM_VC +: NUM_VC];
    assign avail_s = |vc_avail[2*NUM_VC +: NUM_VC];

`ifdef RC_ERR_EN
    logic dst_oob, illegal, err_q;
    assign dst_oob = (32'(dst_x) >= MESH_X) || (32'(dst_y) >= MESH_Y);
    // Only head/single carry a destination; bodies are judged by FSM state alone.
    assign illegal = is_start ? ((state_q[ivc] == LOCKED) || dst_oob) : (state_q[ivc] == IDLE);
    assign fwd_d   = is_start || (state_q[ivc] == LOCKED);
    assign err[p]  = err_q;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q <= 1'b0;
      else if (xfer && illegal) err_q <= 1'b1;
    end
`else
    assign fwd_d  = 1'b1;
    assign err[p] = 1'b0;
`endif

    // West-first: any westward hop is taken first; otherwise adapt among productive N/S/E.
    always_comb begin
      route_port = P_L;
      if (dst_x == curr_x && dst_y == curr_y) route_port = P_L;
      else if (dst_x < curr_x)                route_port = P_W;
      else if (prod_n && avail_n)             route_port = P_N;
      else if (prod_s && avail_s)             route_port = P_S;
      else if (prod_e && avail_e)             route_port = P_E;
      else if (prod_n)                        route_port = P_N;
      else if (prod_s)                        route_port = P_S;
      else                                    route_port = P_E;
`ifdef RC_ERR_EN
      if (dst_oob) route_port = P_L;
`endif
    end

`ifdef RC_ERR_EN
    assign route_ovc = dst_oob ? '0 : low_vc(vc_avail[route_port*NUM_VC +: NUM_VC]);
`else
    assign route_ovc = low_vc(vc_avail[route_port*NUM_VC +: NUM_VC]);
`endif

    // Head/single use the fresh route; everything else replays the locked route.
    always_comb begin
      port_d = route_port;
      ovc_d  = route_ovc;
      if (!is_start) begin
        port_d = tbl_port_q[ivc];
        ovc_d  = tbl_ovc_q[ivc];
      end
    end

    // Per-VC route FSM and route table; only this port writes its own entries.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int v = 0; v < NUM_VC; v++) begin
          state_q[v]    <= IDLE;
          tbl_port_q[v] <= '0;
          tbl_ovc_q[v]  <= '0;
        end
      end else if (xfer) begin
        if (is_head) begin
          state_q[ivc]    <= LOCKED;
          tbl_port_q[ivc] <= route_port;
          tbl_ovc_q[ivc]  <= route_ovc;
        end else if (is_single || is_tail) begin
          state_q[ivc] <= IDLE;
        end
      end
    end

    // Output slot: refills whenever the downstream side has room, holds otherwise.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        flit_q  <= '0;
        ivc_q   <= '0;
        port_q  <= '0;
        ovc_q   <= '0;
      end else if (in_ready[p]) begin
        valid_q <= xfer && fwd_d;
        if (xfer) begin
          flit_q <= flit;
          ivc_q  <= ivc;
          port_q <= port_d;
          ovc_q  <= ovc_d;
        end
      end
    end

    assign out_valid[p]                = valid_q;
    assign out_flit[p*FLIT_W +: FLIT_W] = flit_q;
    assign out_ivc[p*VC_W +: VC_W]     = ivc_q;
    assign out_port[p*3 +: 3]          = port_q;
    assign out_ovc[p*VC_W +: VC_W]     = ovc_q;
  end

endmodule

// File: tb/tb_rc_vc_route_stage.sv
`timescale 1ns/1ps
module tb_rc_vc_route_stage;

  localparam int FLIT_W = 64;
  localparam int VC_W   = 1;

  localparam int T_HEAD = 0, T_BODY = 1, T_TAIL = 2, T_SING = 3;
  localparam int P_N = 0, P_E = 1, P_S = 2, P_W = 3, P_L = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [2:0]           curr_x, curr_y;
  logic [5*FLIT_W-1:0]  in_flit;
  logic [5*VC_W-1:0]    in_vc;
  logic [4:0]           in_valid, in_ready;
  logic [9:0]           vc_avail;
  logic [5*FLIT_W-1:0]  out_flit;
  logic [5*VC_W-1:0]    out_ivc, out_ovc;
  logic [14:0]          out_port;
  logic [4:0]           out_valid, out_ready, err;

  rc_vc_route_stage #(.FLIT_W(64), .COORD_W(3), .NUM_VC(2), .MESH_X(4), .MESH_Y(4)) dut (
    .clk(clk), .rst(rst), .curr_x(curr_x), .curr_y(curr_y),
    .in_flit(in_flit), .in_vc(in_vc), .in_valid(in_valid), .in_ready(in_ready),
    .vc_avail(vc_avail), .out_flit(out_flit), .out_ivc(out_ivc), .out_port(out_port),
    .out_ovc(out_ovc), .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] flit;
    logic        vc;
    logic [2:0]  port;
    logic        ovc;
  } exp_t;

  typedef struct {
    int p; int vc; int ty; int dx; int dy; int cx; int cy;
    logic [9:0] av;
    int ep; int eo; int ef;
  } vec_t;

  exp_t   sb_q [5][$];
  exp_t   pend_exp [5];
  logic [4:0] pend_fwd;
  vec_t   vecs [$];
  int     n_cmp = 0;
  int     n_err = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic vec_t mk(input int p, input int vc, input int ty, input int dx, input int dy,
                              input int cx, input int cy, input logic [9:0] av,
                              input int ep, input int eo, input int ef);
    vec_t r;
    r.p = p; r.vc = vc; r.ty = ty; r.dx = dx; r.dy = dy; r.cx = cx; r.cy = cy;
    r.av = av; r.ep = ep; r.eo = eo; r.ef = ef;
    return r;
  endfunction

  // Present one flit on port p for the current cycle and record what it must produce.
  task automatic drive(input int p, input int vc, input int ty, input int dx, input int dy,
                       input int cx, input int cy, input logic [9:0] av,
                       input int ep, input int eo, input int ef, input logic [54:0] pl);
    logic [63:0] f;
    f = {3'(dy), 3'(dx), 3'(ty), pl};
    curr_x   = 3'(cx);
    curr_y   = 3'(cy);
    vc_avail = av;
    in_valid = '0;
    in_valid[p] = 1'b1;
    in_flit[p*FLIT_W +: FLIT_W] = f;
    in_vc[p] = 1'(vc);
    pend_exp[p].flit = f;
    pend_exp[p].vc   = 1'(vc);
    pend_exp[p].port = 3'(ep);
    pend_exp[p].ovc  = 1'(eo);
    pend_fwd[p]      = 1'(ef);
  endtask

  task automatic check_drained(input string tag);
    for (int p = 0; p < 5; p++)
      check($sformatf("%s_leftover_p%0d", tag, p), 64'(sb_q[p].size()), 64'd0);
  endtask

  // Scoreboard: push on accepted input, pop on delivered output, peek while stalled.
  always @(negedge clk) begin
    if (rst) begin
      for (int p = 0; p < 5; p++) sb_q[p].delete();
    end else begin
      for (int p = 0; p < 5; p++) begin
        if (out_valid[p]) begin
          if (sb_q[p].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_out_p%0d: got flit %0h, required no output", p, out_flit[p*FLIT_W +: FLIT_W]);
          end else begin
            exp_t e;
            e = out_ready[p] ? sb_q[p].pop_front() : sb_q[p][0];
            check($sformatf("flit_p%0d", p), out_flit[p*FLIT_W +: FLIT_W], e.flit);
            check($sformatf("ivc_p%0d", p),  64'(out_ivc[p]), 64'(e.vc));
            check($sformatf("port_p%0d", p), 64'(out_port[p*3 +: 3]), 64'(e.port));
            check($sformatf("ovc_p%0d", p),  64'(out_ovc[p]), 64'(e.ovc));
          end
        end
        if (in_valid[p] && in_ready[p] && pend_fwd[p]) sb_q[p].push_back(pend_exp[p]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, required finish within budget");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, cyc;
    rst = 1'b1; curr_x = '0; curr_y = '0; in_flit = '0; in_vc = '0;
    in_valid = '0; vc_avail = '0; out_ready = 5'h1f; pend_fwd = '0;
    for (int p = 0; p < 5; p++) pend_exp[p] = '0;

    // Vector table: {port, vc, type, dest x/y, curr x/y, vc_avail, exp port, exp ovc, exp forwarded}
    vecs.push_back(mk(4, 0, T_HEAD, 1, 1, 1, 1, 10'h3FF,          P_L, 0, 1));
    vecs.push_back(mk(4, 0, T_TAIL, 0, 0, 2, 2, 10'h000,          P_L, 0, 1));
    vecs.push_back(mk(0, 0, T_HEAD, 0, 3, 2, 1, 10'b11_10_11_11_11, P_W, 1, 1));
    vecs.push_back(mk(0, 0, T_BODY, 3, 3, 0, 0, 10'h000,          P_W, 1, 1));
    vecs.push_back(mk(0, 0, T_TAIL, 3, 3, 0, 0, 10'h000,          P_W, 1, 1));
    vecs.push_back(mk(2, 1, T_SING, 3, 3, 1, 1, 10'b11_11_11_10_00, P_E, 1, 1));
    vecs.push_back(mk(2, 1, T_SING, 3, 3, 1, 1, 10'h000,          P_N, 0, 1));
    vecs.push_back(mk(1, 0, T_HEAD, 3, 1, 1, 1, 10'h3FF,          P_E, 0, 1));
    vecs.push_back(mk(1, 1, T_HEAD, 1, 3, 1, 1, 10'b11_11_11_11_10, P_N, 1, 1));
    vecs.push_back(mk(1, 0, T_BODY, 0, 0, 3, 3, 10'h000,          P_E, 0, 1));
    vecs.push_back(mk(1, 1, T_BODY, 0, 0, 3, 3, 10'h000,          P_N, 1, 1));
    vecs.push_back(mk(1, 0, T_TAIL, 0, 0, 3, 3, 10'h000,          P_E, 0, 1));
    vecs.push_back(mk(1, 1, T_TAIL, 0, 0, 3, 3, 10'h000,          P_N, 1, 1));
    vecs.push_back(mk(3, 0, T_SING, 3, 0, 2, 2, 10'b11_11_00_01_11, P_E, 0, 1));
    vecs.push_back(mk(3, 0, T_SING, 2, 0, 2, 2, 10'b11_11_10_11_11, P_S, 1, 1));
    vecs.push_back(mk(4, 1, T_SING, 1, 2, 3, 0, 10'h000,          P_W, 0, 1));
    vecs.push_back(mk(0, 1, T_HEAD, 2, 2, 1, 2, 10'h3FF,          P_E, 0, 1));
    vecs.push_back(mk(0, 1, 5,      0, 0, 0, 0, 10'h000,          P_E, 0, 1));
    vecs.push_back(mk(0, 1, T_TAIL, 0, 0, 0, 0, 10'h000,          P_E, 0, 1));
`ifdef RC_ERR_EN
    vecs.push_back(mk(1, 0, T_SING, 5, 0, 1, 1, 10'h3FF,          P_L, 0, 1));
    vecs.push_back(mk(3, 1, T_BODY, 0, 0, 0, 0, 10'h3FF,          P_N, 0, 0));
`else
    vecs.push_back(mk(1, 0, T_SING, 5, 0, 1, 1, 10'h3FF,          P_S, 0, 1));
    vecs.push_back(mk(3, 1, T_BODY, 0, 0, 0, 0, 10'h3FF,          P_N, 0, 1));
`endif

    // Reset state
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_err",       64'(err),       64'd0);
    check("rst_in_ready",  64'(in_ready),  64'h1f);
    check("rst_out_port",  64'(out_port),  64'd0);
    check("rst_out_ovc",   64'(out_ovc),   64'd0);
    @(posedge clk); #1 rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk); #1;
      drive(vecs[i].p, vecs[i].vc, vecs[i].ty, vecs[i].dx, vecs[i].dy, vecs[i].cx, vecs[i].cy,
            vecs[i].av, vecs[i].ep, vecs[i].eo, vecs[i].ef, 55'($urandom));
    end
    @(posedge clk); #1 in_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef RC_ERR_EN
    check("table_err", 64'(err), 64'h0a);
`else
    check("table_err", 64'(err), 64'h00);
`endif
    check_drained("table");

    // Backpressure on S port: stall 3 cycles with a flit waiting, then full rate
    k = 0; cyc = 0;
    while (k < 6 && cyc < 100) begin
      @(posedge clk); #1;
      out_ready = (cyc >= 1 && cyc <= 3) ? 5'b11011 : 5'b11111;
      drive(2, k % 2, T_SING, k % 4, 0, 0, 0, 10'h3FF, (k % 4 == 0) ? P_L : P_E, 0, 1, 55'(k + 100));
      @(negedge clk);
      check($sformatf("bp_in_ready_c%0d", cyc), 64'(in_ready[2]), (cyc >= 1 && cyc <= 3) ? 64'd0 : 64'd1);
      if (in_ready[2]) k++;
      cyc++;
    end
    check("bp_cycles", 64'(cyc), 64'd9);
    @(posedge clk); #1 in_valid = '0; out_ready = 5'h1f;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_drained("bp");

    // Reset mid-packet: head on W/vc1 stalled in the output slot, then reset
    @(posedge clk); #1;
    out_ready = 5'b10111;
    drive(3, 1, T_HEAD, 3, 0, 0, 0, 10'b11_11_11_10_11, P_E, 1, 1, 55'h1234);
    @(posedge clk); #1 in_valid = '0;
    @(negedge clk);
    check("mid_pre_valid", 64'(out_valid[3]), 64'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_err",   64'(err),       64'd0);
    check("mid_rst_port",  64'(out_port),  64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0; out_ready = 5'h1f;
    // The follow-on body now finds an IDLE VC and a cleared table
    @(posedge clk); #1;
`ifdef RC_ERR_EN
    drive(3, 1, T_BODY, 0, 0, 0, 0, 10'h3FF, P_N, 0, 0, 55'h5678);
`else
    drive(3, 1, T_BODY, 0, 0, 0, 0, 10'h3FF, P_N, 0, 1, 55'h5678);
`endif
    @(posedge clk); #1 in_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
`ifdef RC_ERR_EN
    check("mid_body_err", 64'(err), 64'h08);
`else
    check("mid_body_err", 64'(err), 64'h00);
`endif
    check_drained("mid");

    // Final reset clears any sticky error
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("final_rst_err",   64'(err),       64'd0);
    check("final_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
